// File: rtl/pipe_pkg.sv
// Shared definitions for the npc pipeline stage registers: per-stage widths,
// control-field bit positions and the skid FSM state encoding.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W   = 64;
   localparam int unsigned PIPE_CTRL_W   = 8;

   localparam int unsigned IF_ID_DATA_W  = 64;
   localparam int unsigned IF_ID_CTRL_W  = 8;
   localparam int unsigned ID_EX_DATA_W  = 64;
   localparam int unsigned ID_EX_CTRL_W  = 8;
   localparam int unsigned EX_MEM_DATA_W = 64;
   localparam int unsigned EX_MEM_CTRL_W = 8;
   localparam int unsigned MEM_WB_DATA_W = 64;
   localparam int unsigned MEM_WB_CTRL_W = 8;

   // Bit positions inside the control field; all must read 0 in a bubble.
   localparam int unsigned CTRL_RD_W_EN  = 0;
   localparam int unsigned CTRL_CSR_W_EN = 1;
   localparam int unsigned CTRL_LOAD     = 2;
   localparam int unsigned CTRL_STORE    = 3;
   localparam int unsigned CTRL_MUL_VLD  = 4;
   localparam int unsigned CTRL_DIV_VLD  = 5;
   localparam int unsigned CTRL_EBREAK   = 6;
   localparam int unsigned CTRL_INST_32  = 7;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry {valid, ctrl, data} with load and clear; clear drops the
// entry and forces ctrl to CTRL_RST while the payload is left untouched.
module pipe_entry #(
   parameter int unsigned       DATA_W   = 64,
   parameter int unsigned       CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              q_valid,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_ctrl  <= CTRL_RST;
         // NOTE: the payload is reset too so out_data is defined after reset,
         // even though clear and bubbles never touch it.
         q_data  <= '0;
      end else if (clr) begin
         q_valid <= 1'b0;
         q_ctrl  <= CTRL_RST;
      end else if (load) begin
         q_valid <= 1'b1;
         q_ctrl  <= d_ctrl;
         q_data  <= d_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and stall.
// Define PIPE_STAGE_SKID_EN for a two-entry skid version with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W   = PIPE_DATA_W,
   parameter int unsigned       CTRL_W   = PIPE_CTRL_W,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic take;
   logic push;

   assign take = out_valid & out_ready & ~stall;
   assign push = in_valid & in_ready;

`ifndef PIPE_STAGE_SKID_EN

   assign in_ready = ~out_valid | (out_ready & ~stall);

   // Flush beats push, so a push accepted in the flush cycle is dropped.
   pipe_entry #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush | (take & ~push)),
      .load    (push),
      .d_ctrl  (in_ctrl),
      .d_data  (in_data),
      .q_valid (out_valid),
      .q_ctrl  (out_ctrl),
      .q_data  (out_data)
   );

`else

   pipe_state_e       state;
   pipe_state_e       state_nxt;
   logic              in_ready_q;
   logic              main_clr;
   logic              main_load;
   logic              skid_clr;
   logic              skid_load;
   logic [CTRL_W-1:0] main_d_ctrl;
   logic [DATA_W-1:0] main_d_data;
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != TWO);
      end
   end

   assign in_ready = in_ready_q;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nxt   = state;
      main_clr    = 1'b0;
      main_load   = 1'b0;
      skid_clr    = 1'b0;
      skid_load   = 1'b0;
      main_d_ctrl = in_ctrl;
      main_d_data = in_data;
      if (flush) begin
         state_nxt = EMPTY;
         main_clr  = 1'b1;
         skid_clr  = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  main_load = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (push && !take) begin
                  skid_load = 1'b1;
                  state_nxt = TWO;
               end else if (push && take) begin
                  main_load = 1'b1;
               end else if (take) begin
                  main_clr  = 1'b1;
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               // The older skid entry advances into main, preserving order.
               if (take && skid_valid) begin
                  main_load   = 1'b1;
                  main_d_ctrl = skid_ctrl;
                  main_d_data = skid_data;
                  skid_clr    = 1'b1;
                  state_nxt   = ONE;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   pipe_entry #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .clr     (main_clr),
      .load    (main_load),
      .d_ctrl  (main_d_ctrl),
      .d_data  (main_d_data),
      .q_valid (out_valid),
      .q_ctrl  (out_ctrl),
      .q_data  (out_data)
   );

   pipe_entry #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr     (skid_clr),
      .load    (skid_load),
      .d_ctrl  (in_ctrl),
      .d_data  (in_data),
      .q_valid (skid_valid),
      .q_ctrl  (skid_ctrl),
      .q_data  (skid_data)
   );

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (default single-entry build):
// directed vector table, async reset sequence and a queue-scoreboard random run.
module tb_pipe_stage_reg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              stall;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   int checks   = 0;
   int failures = 0;

   pipe_stage_reg #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST ('0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              iv;
      logic [DATA_W-1:0] id;
      logic [CTRL_W-1:0] ic;
      logic              ordy;
      logic              stl;
      logic              fl;
      logic              exp_ir;
      logic              exp_ov;
      logic [DATA_W-1:0] exp_od;
      logic [CTRL_W-1:0] exp_oc;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } item_t;

   vec_t  vecs[$];
   item_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [DATA_W-1:0] id, input logic [CTRL_W-1:0] ic,
                               input logic ordy, input logic stl, input logic fl, input logic exp_ir,
                               input logic exp_ov, input logic [DATA_W-1:0] exp_od,
                               input logic [CTRL_W-1:0] exp_oc);
      vec_t v;
      v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.stl = stl; v.fl = fl;
      v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_od = exp_od; v.exp_oc = exp_oc;
      return v;
   endfunction

   task automatic drive(input logic iv, input logic [DATA_W-1:0] id, input logic [CTRL_W-1:0] ic,
                        input logic ordy, input logic stl, input logic fl);
      in_valid  = iv;
      in_data   = id;
      in_ctrl   = ic;
      out_ready = ordy;
      stall     = stl;
      flush     = fl;
   endtask

   initial begin
      logic exp_ir;
      logic take;
      logic push;
      item_t it;

      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_ctrl",  64'(out_ctrl),  64'd0);
      check("reset_out_data",  out_data,       64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Streaming: 0x10..0x17 back to back, each visible one edge after push.
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1, 64'h10 + 64'(i), 8'(i + 1), 1, 0, 0, 1, 1, 64'h10 + 64'(i), 8'(i + 1)));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 64'h17, 8'h00));
      // Backpressure: 0x20 held three cycles, then 0x21 follows.
      vecs.push_back(mk(1, 64'h20, 8'h11, 0, 0, 0, 1, 1, 64'h20, 8'h11));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 64'h21, 8'h12, 0, 0, 0, 0, 1, 64'h20, 8'h11));
      vecs.push_back(mk(1, 64'h21, 8'h12, 1, 0, 0, 1, 1, 64'h21, 8'h12));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 64'h21, 8'h00));
      // Stall with out_ready=1: 0x30 held, then delivered once.
      vecs.push_back(mk(1, 64'h30, 8'h22, 1, 0, 0, 1, 1, 64'h30, 8'h22));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(1, 64'h31, 8'h23, 1, 1, 0, 0, 1, 64'h30, 8'h22));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 64'h30, 8'h00));
      // Flush with full stage (ctrl 0xFF) and concurrent push of 0x40.
      vecs.push_back(mk(1, 64'h3F, 8'hFF, 0, 0, 0, 1, 1, 64'h3F, 8'hFF));
      vecs.push_back(mk(1, 64'h40, 8'h33, 1, 0, 1, 1, 0, 64'h3F, 8'h00));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 64'h3F, 8'h00));
      // Flush of a blocked full stage.
      vecs.push_back(mk(1, 64'h50, 8'h44, 0, 0, 0, 1, 1, 64'h50, 8'h44));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h50, 8'h00));

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy, vecs[i].stl, vecs[i].fl);
         #1;
         check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
         @(posedge clk); #1;
         check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
         check($sformatf("vec%0d_out_data", i),  out_data,       vecs[i].exp_od);
         check($sformatf("vec%0d_out_ctrl", i),  64'(out_ctrl),  64'(vecs[i].exp_oc));
      end

      // Async reset mid-handshake: clears between clock edges.
      drive(1'b1, 64'h60, 8'h5A, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("pre_rst_out_valid", 64'(out_valid), 64'd1);
      check("pre_rst_out_ctrl",  64'(out_ctrl),  64'h5A);
      drive(1'b1, 64'h61, 8'h5B, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_out_ctrl",  64'(out_ctrl),  64'd0);
      check("async_rst_out_data",  out_data,       64'd0);
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_release_in_ready",  64'(in_ready),  64'd1);
      check("rst_release_out_valid", 64'(out_valid), 64'd0);

      // Random run against a queue scoreboard.
      sb.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         check("rnd_out_valid", 64'(out_valid), 64'(sb.size() != 0));
         if (sb.size() != 0) begin
            check("rnd_out_data", out_data,      sb[0].data);
            check("rnd_out_ctrl", 64'(out_ctrl), 64'(sb[0].ctrl));
         end else begin
            check("rnd_bubble_ctrl", 64'(out_ctrl), 64'd0);
         end
         it.data = {$urandom, $urandom};
         it.ctrl = 8'($urandom);
         drive($urandom_range(99) < 70, it.data, it.ctrl, $urandom_range(99) < 70,
               $urandom_range(99) < 10, $urandom_range(99) < 10);
         #1;
         exp_ir = (sb.size() == 0) || (out_ready && !stall);
         check("rnd_in_ready", 64'(in_ready), 64'(exp_ir));
         take = (sb.size() != 0) && out_ready && !stall;
         push = in_valid && exp_ir;
         @(posedge clk); #1;
         if (flush) begin
            sb.delete();
         end else begin
            if (take) void'(sb.pop_front());
            if (push) sb.push_back(it);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
